rf_read_arbiter: RTL
====================

RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one register-file read port.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the register data width.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port ctrl_reset, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits, one read request per requester.
REQ-007 The block SHALL have port req_addr, input, NUM_REQ*ADDR_W bits, flattened; requester i uses bits [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits, one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port rsp_stall, input, 1 bit, global hold of the response stage.
REQ-010 The block SHALL have port rsp_valid, output, NUM_REQ bits, one-hot; it marks which requester rsp_data belongs to.
REQ-011 The block SHALL have port rsp_data, output, DATA_W bits, registered read data.
REQ-012 The block SHALL have port rf_raddr, output, ADDR_W bits, driving the shared read-port address.
REQ-013 The block SHALL have port rf_rdata, input, DATA_W bits, the combinational read-port data.
REQ-014 The block SHALL have ports wr_en (1 bit), wr_addr (ADDR_W bits) and wr_data (DATA_W bits), all inputs, mirroring the register-file write port.

Function
REQ-015 The block SHALL grant at most one requester per cycle, round-robin, searching upward (with wrap) from last_grant+1 mod NUM_REQ.
REQ-016 req_ready SHALL be combinational from req_valid, last_grant and rsp_stall, and SHALL be all-zero when rsp_stall=1 or no req_valid bit is set.
REQ-017 rf_raddr SHALL equal the granted requester's address, and SHALL be 0 when nothing is granted.
REQ-018 On a grant, the next rising edge SHALL load rsp_data from rf_rdata, set rsp_valid to the grant vector, and set last_grant to the granted index.
REQ-019 Latency SHALL be exactly 1 cycle from acceptance to rsp_valid; throughput SHALL be one read per cycle.
REQ-020 rsp_valid SHALL pulse for one cycle per accepted request, unless rsp_stall holds it.
REQ-021 With no grant and rsp_stall=0, rsp_valid SHALL clear to 0 at the next edge, and rsp_data SHALL hold its value.
REQ-022 While rsp_stall=1, rsp_valid, rsp_data and last_grant SHALL all hold.
REQ-023 The control state SHALL be two states: IDLE (rsp_valid=0) and RESP (rsp_valid≠0).
REQ-024 State transitions: IDLE→RESP on a grant; RESP→RESP on a grant or on stall; RESP→IDLE when there is no grant and no stall.
REQ-025 A requester that deasserts req_valid without being granted SHALL be dropped with no side effects.
REQ-026 A requester that holds req_valid SHALL be granted within NUM_REQ cycles of rsp_stall being low.

Reset
REQ-027 On ctrl_reset=1 at a clock edge, the block SHALL set rsp_valid=0, rsp_data=0, last_grant=NUM_REQ-1 (so requester 0 wins first) and the state to IDLE.
REQ-028 Reset SHALL take priority over stall and grant; a request accepted in the same cycle as reset SHALL be discarded with no response.
REQ-029 req_ready SHALL be all-zero during any cycle in which ctrl_reset=1.

Configuration
REQ-030 With macro RF_ARB_BYPASS_EN defined: when wr_en=1, wr_addr equals the granted address and wr_addr≠0, the block SHALL capture wr_data into rsp_data instead of rf_rdata.
REQ-031 Without RF_ARB_BYPASS_EN: the block SHALL always capture rf_rdata, and wr_en, wr_addr and wr_data SHALL be ignored but remain as ports.

Structure
REQ-032 Package rf_arb_pkg SHALL hold the default NUM_REQ, ADDR_W and DATA_W constants and the IDLE/RESP state encoding.
REQ-033 The round-robin select SHALL be the sub-module rr_pick (inputs: request vector, last index; output: one-hot grant), instantiated once.

Verification
REQ-034 Reset, then req_valid=4'b1111 held for 4 cycles, SHALL produce grants in order 0,1,2,3, with rsp_valid one-hot following each grant one cycle later.
REQ-035 Requester 2 alone reads address 7 while the port model returns 32'hDEAD_BEEF: the next cycle SHALL show rsp_valid=4'b0100 and rsp_data=32'hDEAD_BEEF.
REQ-036 rsp_stall=1 for 3 cycles while rsp_valid=4'b0010: rsp_valid, rsp_data and req_ready=0 SHALL hold, and grants SHALL resume on the first cycle after stall drops.
REQ-037 Bypass: granted address 9 with wr_en=1, wr_addr=9, wr_data=32'h1234_5678 SHALL give rsp_data=32'h1234_5678 when RF_ARB_BYPASS_EN is defined, else rf_rdata.
REQ-038 Bypass to address 0: with wr_addr=0 and the macro defined, rsp_data SHALL equal rf_rdata.
REQ-039 ctrl_reset asserted in the same cycle as a grant to requester 3: the following cycle SHALL show rsp_valid=0 and rsp_data=0, and the next grant with all requesting SHALL go to requester 0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared constants and control-state encoding for the register-file read arbiter.
package rf_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_read_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester above last_idx, wrapping.
module rr_pick
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        int   idx;
        logic found;
        // NOTE: defaults assigned first so every path drives grant and no latch is inferred.
        grant = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_idx) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_read_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters with a 1-cycle registered response.
// Optional write-to-read bypass enabled by defining RF_ARB_BYPASS_EN.
module rf_read_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rsp_stall,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rf_raddr,
    input  logic [DATA_W-1:0]         rf_rdata,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0]   pick;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [DATA_W-1:0]    capture_data;
    logic                 any_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req_valid),
        .last_idx (last_grant_q),
        .grant    (pick)
    );

    // Stall and reset both suppress acceptance, so nothing is consumed that would be lost.
    assign grant     = (ctrl_reset || rsp_stall) ? '0 : pick;
    assign any_grant = |grant;
    assign req_ready = grant;

    always_comb begin
        grant_idx = '0;
        rf_raddr  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
                rf_raddr  = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

`ifdef RF_ARB_BYPASS_EN
    assign capture_data = (wr_en && (wr_addr == rf_raddr) && (wr_addr != '0)) ? wr_data : rf_rdata;
`else
    assign capture_data = rf_rdata;
    logic unused_wr;
    assign unused_wr = &{1'b0, wr_en, wr_addr, wr_data};
`endif

    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_grant) state_d = RESP;
            end
            RESP: begin
                if (!any_grant && !rsp_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rsp_stall) begin
            rsp_valid_d = grant;
            if (any_grant) begin
                rsp_data_d   = capture_data;
                last_grant_d = grant_idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q      <= IDLE;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = (state_q == RESP) ? rsp_valid_q : '0;
    assign rsp_data  = rsp_data_q;

endmodule
